// File: rtl/cam_array_if.sv
// CAM request/response bundle shared by the requester and the CAM array.
//
// Handshake: every request (read_i, write_i, search_i) is a single-cycle
// strobe sampled on the rising clock edge together with its index/data
// fields. The CAM has no backpressure and accepts every request on every
// cycle. Each response strobe (read_valid_o, search_valid_o) is high for
// exactly one cycle, and its data field is meaningful only while the strobe
// is high.
interface cam_array_if #(
    parameter int ARRAY_WIDTH_LOG2 = 5,
    parameter int ARRAY_SIZE_LOG2  = 5
);
    localparam int W  = 1 << ARRAY_WIDTH_LOG2;
    localparam int IW = ARRAY_SIZE_LOG2;

    logic          read_i;
    logic [IW-1:0] read_index_i;
    logic          write_i;
    logic [IW-1:0] write_index_i;
    logic [W-1:0]  write_data_i;
    logic          search_i;
    logic [W-1:0]  search_data_i;
    logic          read_valid_o;
    logic [W-1:0]  read_value_o;
    logic          search_valid_o;
    logic [IW-1:0] search_index_o;

    modport master (
        output read_i, read_index_i, write_i, write_index_i, write_data_i,
               search_i, search_data_i,
        input  read_valid_o, read_value_o, search_valid_o, search_index_o
    );

    modport slave (
        input  read_i, read_index_i, write_i, write_index_i, write_data_i,
               search_i, search_data_i,
        output read_valid_o, read_value_o, search_valid_o, search_index_o
    );
endinterface

// File: rtl/cam_array.sv
// Content-addressable memory: 2**ARRAY_SIZE_LOG2 entries of
// 2**ARRAY_WIDTH_LOG2 bits, each with a valid bit. Reads answer one cycle
// after the request; searches use a two-stage pipeline (match vector, then a
// lowest-index priority encode) and answer two cycles after the request.
// All outputs are registered.
module cam_array #(
    parameter int ARRAY_WIDTH_LOG2 = 5,
    parameter int ARRAY_SIZE_LOG2  = 5
) (
    input  logic        clk,
    input  logic        reset,
    cam_array_if.slave  bus
);
    localparam int W  = 1 << ARRAY_WIDTH_LOG2;
    localparam int N  = 1 << ARRAY_SIZE_LOG2;
    localparam int IW = ARRAY_SIZE_LOG2;

    typedef logic [IW-1:0] idx_t;

    logic [W-1:0] mem [N];
    logic [N-1:0] valid_q;

    // Search stage 1 registers: match vector plus its stage-valid flag.
    logic [N-1:0] match_d;
    logic [N-1:0] match_q;
    logic         s1_valid_q;

    // Stage 2 combinational priority encode of the registered match vector.
    idx_t         enc_idx;
    logic         enc_hit;

    // Storage update; reads and searches at the same edge see the old contents
    // because they sample mem/valid_q before these non-blocking updates land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                mem[k] <= '0;
            end
            valid_q <= '0;
        end else if (bus.write_i) begin
            mem[bus.write_index_i]     <= bus.write_data_i;
            valid_q[bus.write_index_i] <= 1'b1;
        end
    end

    // Registered read port; the value holds between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.read_valid_o <= 1'b0;
            bus.read_value_o <= '0;
        end else begin
            bus.read_valid_o <= bus.read_i;
            if (bus.read_i) begin
                bus.read_value_o <= mem[bus.read_index_i];
            end
        end
    end

    // Compare the search key against every valid entry in parallel.
    always_comb begin
        match_d = '0;
        for (int k = 0; k < N; k++) begin
            match_d[k] = valid_q[k] && (mem[k] == bus.search_data_i);
        end
    end

    // Search stage 1: capture the match vector so later writes cannot alter it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q    <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            match_q    <= match_d;
            s1_valid_q <= bus.search_i;
        end
    end

    // Lowest set bit wins: scanning downward lets lower indices overwrite.
    always_comb begin
        enc_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (match_q[k]) begin
                enc_idx = idx_t'(k);
            end
        end
        enc_hit = s1_valid_q && (|match_q);
    end

    // Search stage 2: register the result; a miss or idle cycle reports index 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.search_valid_o <= 1'b0;
            bus.search_index_o <= '0;
        end else begin
            bus.search_valid_o <= enc_hit;
            bus.search_index_o <= enc_hit ? enc_idx : '0;
        end
    end
endmodule

// File: tb/tb_cam_array.sv
// Directed bench for cam_array: hand-computed read/search results checked
// with immediate assertions, ending in a single summary line.
module tb_cam_array;
    localparam int AWL = 5;
    localparam int ASL = 5;
    localparam int W   = 1 << AWL;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Expected {search_valid, search_index} for pipelined searches.
    logic [ASL:0] exp_q[$];

    cam_array_if #(.ARRAY_WIDTH_LOG2(AWL), .ARRAY_SIZE_LOG2(ASL)) bus ();

    cam_array #(.ARRAY_WIDTH_LOG2(AWL), .ARRAY_SIZE_LOG2(ASL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.read_i        = 1'b0;
        bus.write_i       = 1'b0;
        bus.search_i      = 1'b0;
    endtask

    task automatic do_write(input logic [ASL-1:0] idx, input logic [W-1:0] data);
        bus.write_i       = 1'b1;
        bus.write_index_i = idx;
        bus.write_data_i  = data;
        tick();
        bus.write_i       = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ASL-1:0] idx, input logic [W-1:0] exp);
        bus.read_i       = 1'b1;
        bus.read_index_i = idx;
        tick();
        bus.read_i       = 1'b0;
        check({tag, "_rvalid"}, 64'(bus.read_valid_o), 64'd1);
        check({tag, "_rvalue"}, 64'(bus.read_value_o), 64'(exp));
    endtask

    // Single search; checks there is no early strobe, then the result.
    task automatic do_search(input string tag, input logic [W-1:0] key,
                             input logic hit, input logic [ASL-1:0] idx);
        bus.search_i      = 1'b1;
        bus.search_data_i = key;
        tick();
        bus.search_i      = 1'b0;
        check({tag, "_early"}, 64'(bus.search_valid_o), 64'd0);
        tick();
        check({tag, "_svalid"}, 64'(bus.search_valid_o), 64'(hit));
        check({tag, "_sindex"}, 64'(bus.search_index_o), 64'(idx));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.read_index_i  = '0;
        bus.write_index_i = '0;
        bus.write_data_i  = '0;
        bus.search_data_i = '0;
        idle();
        tick();
        tick();
        check("rst_rvalid", 64'(bus.read_valid_o), 64'd0);
        check("rst_rvalue", 64'(bus.read_value_o), 64'd0);
        check("rst_svalid", 64'(bus.search_valid_o), 64'd0);
        check("rst_sindex", 64'(bus.search_index_o), 64'd0);
        reset = 1'b1;
        tick();

        // 1: empty array reads zero; search for 0 misses since nothing is valid.
        do_read("t1_rd7", 5'd7, 32'h0);
        do_search("t1_srch0", 32'h0, 1'b0, 5'd0);

        // 2: write/read/search of a single entry, plus read-value hold.
        do_write(5'd3, 32'hDEADBEEF);
        do_read("t2_rd3", 5'd3, 32'hDEADBEEF);
        tick();
        check("t2_rvalid_low", 64'(bus.read_valid_o), 64'd0);
        check("t2_rvalue_hold", 64'(bus.read_value_o), 64'hDEADBEEF);
        do_search("t2_srch", 32'hDEADBEEF, 1'b1, 5'd3);
        tick();
        check("t2_strobe_once", 64'(bus.search_valid_o), 64'd0);

        // 3: lowest matching index wins; overwrite moves the winner.
        do_write(5'd9,  32'hA5A5A5A5);
        do_write(5'd4,  32'hA5A5A5A5);
        do_write(5'd20, 32'hA5A5A5A5);
        do_search("t3_srch_a", 32'hA5A5A5A5, 1'b1, 5'd4);
        do_write(5'd4,  32'h0);
        do_search("t3_srch_b", 32'hA5A5A5A5, 1'b1, 5'd9);

        // 4: same-edge write, search and read all see pre-write contents.
        do_write(5'd5, 32'h22222222);
        bus.write_i       = 1'b1;
        bus.write_index_i = 5'd5;
        bus.write_data_i  = 32'h11111111;
        bus.search_i      = 1'b1;
        bus.search_data_i = 32'h11111111;
        bus.read_i        = 1'b1;
        bus.read_index_i  = 5'd5;
        tick();
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
        check("t4_rd_old", 64'(bus.read_value_o), 64'h22222222);
        check("t4_rd_valid", 64'(bus.read_valid_o), 64'd1);
        tick();
        bus.search_i = 1'b0;
        check("t4_miss_valid", 64'(bus.search_valid_o), 64'd0);
        check("t4_miss_index", 64'(bus.search_index_o), 64'd0);
        tick();
        check("t4_hit_valid", 64'(bus.search_valid_o), 64'd1);
        check("t4_hit_index", 64'(bus.search_index_o), 64'd5);

        // 5: back-to-back searches, one result per cycle in order.
        do_write(5'd1, 32'h01010101);
        do_write(5'd2, 32'h02020202);
        exp_q.push_back({1'b1, 5'd1});
        exp_q.push_back({1'b1, 5'd2});
        exp_q.push_back({1'b1, 5'd3});
        exp_q.push_back({1'b0, 5'd0});
        for (int i = 0; i < 5; i++) begin
            bus.search_i = (i < 4);
            case (i)
                0: bus.search_data_i = 32'h01010101;
                1: bus.search_data_i = 32'h02020202;
                2: bus.search_data_i = 32'hDEADBEEF;
                default: bus.search_data_i = 32'h33333333;
            endcase
            tick();
            if (i >= 1) begin
                logic [ASL:0] e;
                e = exp_q.pop_front();
                check($sformatf("t5_b2b%0d", i - 1),
                      64'({bus.search_valid_o, bus.search_index_o}), 64'(e));
            end
        end
        bus.search_i = 1'b0;
        check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

        // 6: reset while a hitting search and a read are in flight.
        bus.search_i      = 1'b1;
        bus.search_data_i = 32'hDEADBEEF;
        bus.read_i        = 1'b1;
        bus.read_index_i  = 5'd3;
        tick();
        bus.search_i = 1'b0;
        bus.read_i   = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_rst_svalid", 64'(bus.search_valid_o), 64'd0);
        check("t6_rst_rvalid", 64'(bus.read_valid_o), 64'd0);
        check("t6_rst_rvalue", 64'(bus.read_value_o), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_no_pulse%0d", i), 64'(bus.search_valid_o), 64'd0);
            check($sformatf("t6_sindex%0d", i), 64'(bus.search_index_o), 64'd0);
        end
        do_read("t6_rd3", 5'd3, 32'h0);
        do_search("t6_srch", 32'hDEADBEEF, 1'b0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
